shift_add_multiplier: RTL and testbench

Sequential unsigned multiplier for the calculator datapath, one partial product per clock. Sits directly upstream of full_adder: each cycle it presents the accumulator and a gated multiplicand as the adder's operands and consumes the sum. Operand intake and result delivery each use a valid/ready handshake. It returns the low DATA_WIDTH bits of the product plus an overflow flag.

---
 rtl/shift_add_multiplier.sv | 113 +++++++++++
 tb/tb_shift_add_multiplier.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Purpose: sequential unsigned multiplier, one shift-add partial product per clock; low half of product plus overflow.
// Latency: out_valid rises DATA_WIDTH cycles after the accepting edge (next cycle for zero operands when MULT_ZERO_BYPASS_EN is defined).
// Backpressure: in_ready only in IDLE; result/overflow held in DONE until out_ready, in_ready returns the cycle after handoff.

module full_adder #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b + {{(WIDTH-1){1'b0}}, carry_in};
endmodule

module shift_add_multiplier #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   mcand;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [CW-1:0]           count;
    logic [DATA_WIDTH:0]     add_a;
    logic [DATA_WIDTH:0]     add_b;
    logic [DATA_WIDTH:0]     sum;
    logic                    zero_op;

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Extra top bit of the adder keeps the carry-out so the shift loses nothing.
    assign add_a = {1'b0, prod[2*DATA_WIDTH-1:DATA_WIDTH]};
    assign add_b = prod[0] ? {1'b0, mcand} : '0;

    full_adder #(.WIDTH(DATA_WIDTH + 1)) u_adder (
        .a        (add_a),
        .b        (add_b),
        .carry_in (1'b0),
        .sum      (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = zero_op ? DONE : RUN;
            end
            RUN: begin
                if (count == LAST_COUNT) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand <= '0;
            prod  <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        prod  <= zero_op ? '0 : {{DATA_WIDTH{1'b0}}, b};
                        count <= '0;
                    end
                end
                RUN: begin
                    prod  <= {sum, prod[DATA_WIDTH-1:1]};
                    count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result   = prod[DATA_WIDTH-1:0];
    assign overflow = |prod[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (DATA_WIDTH=16): latency, arithmetic corners, backpressure, reset abort, input isolation.
module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_add_multiplier #(.DATA_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; returns edges counted after the accepting edge, -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    // Present a/b and clock the accepting edge; in_valid drops afterwards.
    task automatic accept(input logic [15:0] av, input logic [15:0] bv);
        a = av; b = bv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        tick(); tick();
        rst_n = 1'b1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (result !== 16'h0)   begin n_fail++; $display("FAIL reset_result got %h want 0000", result); end
        n_cmp++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        accept(16'd3, 16'd5);
        wait_valid(lat);
        n_cmp++; if (lat != 16)             begin n_fail++; $display("FAIL basic_latency got %0d want 16", lat); end
        n_cmp++; if (result !== 16'h000F)   begin n_fail++; $display("FAIL basic_result got %h want 000f", result); end
        n_cmp++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL basic_overflow got %b want 0", overflow); end
        tick();
        n_cmp++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL basic_in_ready_after got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL basic_out_valid_after got %b want 0", out_valid); end
    endtask

    task automatic test_max();
        int lat;
        out_ready = 1'b1;
        accept(16'hFFFF, 16'hFFFF);
        wait_valid(lat);
        n_cmp++; if (result !== 16'h0001) begin n_fail++; $display("FAIL max_result got %h want 0001", result); end
        n_cmp++; if (overflow !== 1'b1)   begin n_fail++; $display("FAIL max_overflow got %b want 1", overflow); end
        tick();
        accept(16'h0100, 16'h0100);
        wait_valid(lat);
        n_cmp++; if (result !== 16'h0000) begin n_fail++; $display("FAIL pow2_result got %h want 0000", result); end
        n_cmp++; if (overflow !== 1'b1)   begin n_fail++; $display("FAIL pow2_overflow got %b want 1", overflow); end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad_hold = 0;
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h0002; in_valid = 1'b1;
        tick();
        a = 16'h1111; b = 16'h0003;
        wait_valid(lat);
        n_cmp++; if (lat != 16)            begin n_fail++; $display("FAIL bp_latency got %0d want 16", lat); end
        n_cmp++; if (result !== 16'h2468)  begin n_fail++; $display("FAIL bp_result got %h want 2468", result); end
        n_cmp++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL bp_overflow got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (result !== 16'h2468 || overflow !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad_hold++;
        end
        n_cmp++; if (bad_hold != 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad_hold); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL bp_in_ready_after_handoff got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL bp_out_valid_after_handoff got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL bp_second_accept in_ready got %b want 0", in_ready); end
        wait_valid(lat);
        n_cmp++; if (lat != 16)            begin n_fail++; $display("FAIL bp_second_latency got %0d want 16", lat); end
        n_cmp++; if (result !== 16'h3333)  begin n_fail++; $display("FAIL bp_second_result got %h want 3333", result); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int stray = 0;
        out_ready = 1'b1;
        accept(16'd7, 16'd9);
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        n_cmp++; if (result !== 16'h0)   begin n_fail++; $display("FAIL rst_mid_result got %h want 0000", result); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0) stray++;
        end
        n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL rst_mid_stray_valid got %0d cycles want 0", stray); end
        accept(16'd2, 16'd4);
        wait_valid(lat);
        n_cmp++; if (lat != 16)           begin n_fail++; $display("FAIL rst_mid_next_latency got %0d want 16", lat); end
        n_cmp++; if (result !== 16'h0008) begin n_fail++; $display("FAIL rst_mid_next_result got %h want 0008", result); end
        tick();
    endtask

    task automatic test_zero();
        int lat;
        int exp_lat;
`ifdef MULT_ZERO_BYPASS_EN
        exp_lat = 0;
`else
        exp_lat = 16;
`endif
        out_ready = 1'b1;
        accept(16'h0000, 16'h00AB);
        wait_valid(lat);
        n_cmp++; if (lat != exp_lat)      begin n_fail++; $display("FAIL zero_latency got %0d want %0d", lat, exp_lat); end
        n_cmp++; if (result !== 16'h0000) begin n_fail++; $display("FAIL zero_result got %h want 0000", result); end
        n_cmp++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL zero_overflow got %b want 0", overflow); end
        tick();
    endtask

    task automatic test_isolation();
        int lat = 0;
        out_ready = 1'b1;
        accept(16'h00FF, 16'h0101);
        while (!out_valid && lat < 100) begin
            a = 16'($urandom);
            b = 16'($urandom);
            tick();
            lat++;
        end
        n_cmp++; if (lat != 16)           begin n_fail++; $display("FAIL iso_latency got %0d want 16", lat); end
        n_cmp++; if (result !== 16'hFFFF) begin n_fail++; $display("FAIL iso_result got %h want ffff", result); end
        n_cmp++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL iso_overflow got %b want 0", overflow); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_reset_mid();
        test_zero();
        test_isolation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
